// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, arbiter
// states and byte/halfword lane selects.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic {
      S_CPU  = 1'b0,
      S_HOST = 1'b1
   } state_t;

   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;
   localparam logic       LANE_HLO = 1'b0;
   localparam logic       LANE_HHI = 1'b1;

   // Size code 11 is not a legal encoding and behaves as a word access.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational lane logic: merges sub-word store data into the current RAM
// word and extracts/extends sub-word load data.
module dmem_lane_merge
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] spo,
   output logic [31:0] merged_wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = spo[7:0];
      case (addr)
         LANE_B0: byte_sel = spo[7:0];
         LANE_B1: byte_sel = spo[15:8];
         LANE_B2: byte_sel = spo[23:16];
         LANE_B3: byte_sel = spo[31:24];
         default: byte_sel = spo[7:0];
      endcase
      half_sel = (addr[1] == LANE_HHI) ? spo[31:16] : spo[15:0];
   end

   // Every bit of the merged word starts as the old RAM contents, so only
   // the addressed lane is overwritten.
   always_comb begin
      merged_wdata = spo;
      load_data    = spo;
      if (size == SZ_B) begin
         case (addr)
            LANE_B0: merged_wdata[7:0]   = wdata[7:0];
            LANE_B1: merged_wdata[15:8]  = wdata[7:0];
            LANE_B2: merged_wdata[23:16] = wdata[7:0];
            LANE_B3: merged_wdata[31:24] = wdata[7:0];
            default: merged_wdata[7:0]   = wdata[7:0];
         endcase
         load_data = {{24{!unsigned_ld && byte_sel[7]}}, byte_sel};
      end else if (size == SZ_H) begin
         if (addr[1] == LANE_HLO) begin
            merged_wdata[15:0] = wdata[15:0];
         end else begin
            merged_wdata[31:16] = wdata[15:0];
         end
         load_data = {{16{!unsigned_ld && half_sel[15]}}, half_sel};
      end else begin
         merged_wdata = wdata;
         load_data    = spo;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: shares one RAM port between the core and a host
// loader. Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W        = 14,
   parameter int HOST_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [1:0]        cpu_size,
   input  logic              cpu_unsigned,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   output logic              misalign_err,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [31:0]       host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [31:0]       host_rdata,
   output logic [ADDR_W-1:0] ram_a,
   output logic [31:0]       ram_d,
   output logic              ram_we,
   input  logic [31:0]       ram_spo
);

   localparam int CNT_W = $clog2(HOST_MAX_WAIT) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_MAX_WAIT - 1);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  wait_cnt;
   logic              misalign;
   logic [31:0]       merged_wdata;
   logic [31:0]       load_data;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2]};

   dmem_lane_merge u_lane_merge (
      .size         (cpu_size),
      .unsigned_ld  (cpu_unsigned),
      .addr         (cpu_addr[1:0]),
      .wdata        (cpu_wdata),
      .spo          (ram_spo),
      .merged_wdata (merged_wdata),
      .load_data    (load_data)
   );

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = cpu_req && (state == S_CPU) &&
                     (((cpu_size == SZ_H) && cpu_addr[0]) ||
                      (is_word(cpu_size) && (cpu_addr[1:0] != 2'b00)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= misalign;
      end
   end
`else
   assign misalign     = 1'b0;
   assign misalign_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_CPU;
      end else begin
         state <= next_state;
      end
   end

   // The host is admitted on an idle CPU cycle, or once it has been denied
   // HOST_MAX_WAIT consecutive cycles; it keeps the RAM only while the CPU stays idle.
   always_comb begin
      next_state = state;
      case (state)
         S_CPU: begin
            if (host_req && (!cpu_req || (wait_cnt == CNT_MAX))) begin
               next_state = S_HOST;
            end
         end
         S_HOST: begin
            next_state = (host_req && !cpu_req) ? S_HOST : S_CPU;
         end
         default: next_state = S_CPU;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (!host_req || ((state == S_CPU) && (next_state == S_HOST))) begin
         wait_cnt <= '0;
      end else if ((state == S_CPU) && cpu_req && (wait_cnt != CNT_MAX)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
      end else begin
         host_rvalid <= host_gnt && !host_we;
         if (host_gnt && !host_we) begin
            host_rdata <= ram_spo;
         end
      end
   end

   assign host_gnt  = (state == S_HOST);
   assign cpu_stall = cpu_req && host_gnt;
   assign cpu_rdata = misalign ? 32'h0 : load_data;

   // Write enable is qualified by rst_n so an abandoned access cannot land.
   always_comb begin
      ram_a  = cpu_addr[ADDR_W+1:2];
      ram_d  = merged_wdata;
      ram_we = rst_n && cpu_req && cpu_we && !misalign;
      if (host_gnt) begin
         ram_a  = host_addr;
         ram_d  = host_wdata;
         ram_we = rst_n && host_we;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, hand-written
// arbitration/reset sequences and a randomized run against a reference model.
module tb_dmem_ctrl;

   localparam int ADDR_W = 14;
   localparam int MAXW   = 4;

   logic              clk;
   logic              rst_n;
   logic              cpu_req;
   logic              cpu_we;
   logic [1:0]        cpu_size;
   logic              cpu_unsigned;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_stall;
   logic              misalign_err;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [31:0]       host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [31:0]       host_rdata;
   logic [ADDR_W-1:0] ram_a;
   logic [31:0]       ram_d;
   logic              ram_we;
   logic [31:0]       ram_spo;

   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic [31:0] ref_mem [0:15];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rdata;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [12];

   dmem_ctrl #(.ADDR_W(ADDR_W), .HOST_MAX_WAIT(MAXW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_size     (cpu_size),
      .cpu_unsigned (cpu_unsigned),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_stall    (cpu_stall),
      .misalign_err (misalign_err),
      .host_req     (host_req),
      .host_we      (host_we),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_gnt     (host_gnt),
      .host_rvalid  (host_rvalid),
      .host_rdata   (host_rdata),
      .ram_a        (ram_a),
      .ram_d        (ram_d),
      .ram_we       (ram_we),
      .ram_spo      (ram_spo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with asynchronous read and synchronous write
   assign ram_spo = mem[ram_a];
   always @(posedge clk) begin
      if (ram_we) mem[ram_a] <= ram_d;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic creq, input logic cwe, input logic [1:0] csize,
                                input logic cuns, input logic [31:0] caddr, input logic [31:0] cwdata,
                                input logic hreq, input logic hwe, input logic [ADDR_W-1:0] haddr,
                                input logic [31:0] hwdata);
      cpu_req      = creq;
      cpu_we       = cwe;
      cpu_size     = csize;
      cpu_unsigned = cuns;
      cpu_addr     = caddr;
      cpu_wdata    = cwdata;
      host_req     = hreq;
      host_we      = hwe;
      host_addr    = haddr;
      host_wdata   = hwdata;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, '0, 32'h0);
         @(posedge clk); #1;
      end
   endtask

   task automatic preload(input logic [ADDR_W-1:0] waddr, input logic [31:0] data);
      logic got;
      got = 1'b0;
      applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 1, 1, waddr, data);
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = host_gnt;
         @(posedge clk); #1;
      end
      if (!got) checkOutput("preload_gnt_timeout", 32'(got), 32'h1);
      idle(3);
   endtask

   // Reference behaviour expressed with masks and shifts on whole words
   function automatic logic [31:0] refStore(input logic [31:0] old, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
      int sh;
      logic [31:0] mask;
      if (size == 2'b00) begin
         sh   = 8 * int'(addr[1:0]);
         mask = 32'hFF << sh;
         return (old & ~mask) | ((wdata & 32'hFF) << sh);
      end else if (size == 2'b01) begin
         sh   = 16 * int'(addr[1]);
         mask = 32'hFFFF << sh;
         return (old & ~mask) | ((wdata & 32'hFFFF) << sh);
      end
      return wdata;
   endfunction

   function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [1:0] size,
                                           input logic uns, input logic [31:0] addr);
      logic [31:0] v;
      if (size == 2'b00) begin
         v = (word >> (8 * int'(addr[1:0]))) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFFFF00;
         return v;
      end else if (size == 2'b01) begin
         v = (word >> (16 * int'(addr[1]))) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF0000;
         return v;
      end
      return word;
   endfunction

   logic        h_req, h_we, owns, nxt_owns, exp_rv, nxt_rv, got_first;
   logic [31:0] h_wdata, exp_hrdata, c_addr, c_wdata;
   logic [ADDR_W-1:0] h_addr;
   logic        c_req, c_we, c_uns;
   logic [1:0]  c_size;
   int          denials, gnt_at, stalls, rv_seen, w, lo;
   logic [31:0] saved;

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, '0, 32'h0);
      #12;
      checkOutput("rst_host_gnt", 32'(host_gnt), 32'h0);
      checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'h0);
      checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
      checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'h0);
      checkOutput("rst_host_rdata", host_rdata, 32'h0);
      checkOutput("rst_misalign_err", 32'(misalign_err), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      //         we  size   uns addr   wdata         init          exp_rdata     exp_word
      vecs[0]  = '{1, 2'b00, 0, 32'h6, 32'h000000AB, 32'h11223344, 32'h0,        32'h11AB3344};
      vecs[1]  = '{0, 2'b00, 0, 32'h6, 32'h0,        32'h11AB3344, 32'hFFFFFFAB, 32'h11AB3344};
      vecs[2]  = '{0, 2'b00, 1, 32'h6, 32'h0,        32'h11AB3344, 32'h000000AB, 32'h11AB3344};
      vecs[3]  = '{1, 2'b01, 0, 32'h2, 32'h00001234, 32'hDEADBEEF, 32'h0,        32'h1234BEEF};
      vecs[4]  = '{0, 2'b01, 0, 32'h2, 32'h0,        32'h1234BEEF, 32'h00001234, 32'h1234BEEF};
      vecs[5]  = '{0, 2'b10, 0, 32'h8, 32'h0,        32'h80000001, 32'h80000001, 32'h80000001};
      vecs[6]  = '{0, 2'b01, 0, 32'h0, 32'h0,        32'h12348765, 32'hFFFF8765, 32'h12348765};
      vecs[7]  = '{0, 2'b01, 1, 32'h0, 32'h0,        32'h12348765, 32'h00008765, 32'h12348765};
      vecs[8]  = '{0, 2'b00, 0, 32'h3, 32'h0,        32'h7F000000, 32'h0000007F, 32'h7F000000};
      vecs[9]  = '{1, 2'b11, 0, 32'hC, 32'hA5A55A5A, 32'h00000000, 32'h0,        32'hA5A55A5A};
      vecs[10] = '{0, 2'b10, 1, 32'h10, 32'h0,       32'hF0000000, 32'hF0000000, 32'hF0000000};
      vecs[11] = '{1, 2'b00, 0, 32'h1, 32'h0000FF12, 32'h00000000, 32'h0,        32'h00001200};

      for (int i = 0; i < 12; i++) begin
         preload(ADDR_W'(vecs[i].addr[31:2]), vecs[i].init);
         applyStimulus(1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                       0, 0, '0, 32'h0);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'h0);
         if (!vecs[i].we) checkOutput($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
         @(posedge clk); #1;
         idle(1);
         checkOutput($sformatf("vec%0d_word", i), mem[vecs[i].addr[15:2]], vecs[i].exp_word);
      end

      // Host write then host read with the CPU idle
      applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 1, 1, ADDR_W'(5), 32'hCAFEF00D);
      @(negedge clk);
      checkOutput("hw_gnt_req_cycle", 32'(host_gnt), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hw_gnt_next_cycle", 32'(host_gnt), 32'h1);
      checkOutput("hw_ram_we", 32'(ram_we), 32'h1);
      @(posedge clk); #1;
      idle(3);
      checkOutput("hw_mem5", mem[5], 32'hCAFEF00D);

      applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 1, 0, ADDR_W'(5), 32'h0);
      @(negedge clk);
      checkOutput("hr_gnt_c0", 32'(host_gnt), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("hr_gnt_c1", 32'(host_gnt), 32'h1);
      checkOutput("hr_rvalid_c1", 32'(host_rvalid), 32'h0);
      @(posedge clk); #1;
      applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, ADDR_W'(5), 32'h0);
      @(negedge clk);
      checkOutput("hr_rvalid_c2", 32'(host_rvalid), 32'h1);
      checkOutput("hr_rdata_c2", host_rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
      idle(3);

      // Starvation bound under continuous CPU traffic
      gnt_at = -1;
      stalls = 0;
      applyStimulus(1, 0, 2'b10, 0, 32'h0, 32'h0, 1, 0, ADDR_W'(1), 32'h0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         got_first = host_gnt && (gnt_at < 0);
         if (got_first) gnt_at = k;
         if (cpu_stall) stalls++;
         @(posedge clk); #1;
         if (got_first) host_req = 1'b0;
      end
      checkOutput("starve_gnt_cycle", 32'(gnt_at), 32'd4);
      checkOutput("starve_stall_cycles", 32'(stalls), 32'd1);
      idle(3);

      // Reset during a host grant: write (ram_we) and read (rvalid) variants
      preload(ADDR_W'(7), 32'h01020304);
      for (int hw = 1; hw >= 0; hw--) begin
         applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 1, 1'(hw), ADDR_W'(7), 32'hBAD0BAD0);
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput($sformatf("rstgnt%0d_gnt_before", hw), 32'(host_gnt), 32'h1);
         checkOutput($sformatf("rstgnt%0d_we_before", hw), 32'(ram_we), 32'(hw));
         #1 rst_n = 1'b0;
         #1;
         checkOutput($sformatf("rstgnt%0d_gnt", hw), 32'(host_gnt), 32'h0);
         checkOutput($sformatf("rstgnt%0d_ram_we", hw), 32'(ram_we), 32'h0);
         @(posedge clk); #1;
         applyStimulus(0, 0, 2'b10, 0, 32'h0, 32'h0, 0, 0, '0, 32'h0);
         rst_n = 1'b1;
         rv_seen = 0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (host_rvalid) rv_seen++;
            @(posedge clk); #1;
         end
         checkOutput($sformatf("rstgnt%0d_no_rvalid", hw), 32'(rv_seen), 32'h0);
         checkOutput($sformatf("rstgnt%0d_mem7", hw), mem[7], 32'h01020304);
      end

`ifdef DMEM_MISALIGN_TRAP_EN
      preload(ADDR_W'(0), 32'h55667788);
      applyStimulus(1, 1, 2'b10, 0, 32'h3, 32'hFFFFFFFF, 0, 0, '0, 32'h0);
      @(negedge clk);
      checkOutput("mis_sw_ram_we", 32'(ram_we), 32'h0);
      checkOutput("mis_err_same_cycle", 32'(misalign_err), 32'h0);
      @(posedge clk); #1;
      applyStimulus(1, 0, 2'b01, 0, 32'h1, 32'h0, 0, 0, '0, 32'h0);
      @(negedge clk);
      checkOutput("mis_err_pulse", 32'(misalign_err), 32'h1);
      checkOutput("mis_lh_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #1;
      idle(1);
      @(negedge clk);
      checkOutput("mis_err_after", 32'(misalign_err), 32'h0);
      checkOutput("mis_mem0", mem[0], 32'h55667788);
      @(posedge clk); #1;
`else
      preload(ADDR_W'(0), 32'h55667788);
      applyStimulus(1, 1, 2'b10, 0, 32'h3, 32'h89ABCDEF, 0, 0, '0, 32'h0);
      @(posedge clk); #1;
      applyStimulus(1, 0, 2'b01, 0, 32'h3, 32'h0, 0, 0, '0, 32'h0);
      @(negedge clk);
      checkOutput("align_lh_rdata", cpu_rdata, 32'hFFFF89AB);
      checkOutput("align_err_tied", 32'(misalign_err), 32'h0);
      @(posedge clk); #1;
      idle(1);
      checkOutput("align_mem0", mem[0], 32'h89ABCDEF);
`endif

      // Randomized traffic against the reference model
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         preload(ADDR_W'(i), ref_mem[i]);
      end
      owns = 1'b0; denials = 0; exp_rv = 1'b0; exp_hrdata = 32'h0;
      h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = 32'h0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         c_req  = ($urandom_range(0, 3) != 0);
         c_we   = 1'($urandom_range(0, 1));
         c_size = 2'($urandom_range(0, 3));
         c_uns  = 1'($urandom_range(0, 1));
         w      = $urandom_range(0, 15);
         lo     = $urandom_range(0, 3);
`ifdef DMEM_MISALIGN_TRAP_EN
         if (c_size == 2'b01) lo = lo & 2;
         else if (c_size[1]) lo = 0;
`endif
         c_addr  = {16'($urandom_range(0, 65535)), 10'h0, 4'(w), 2'(lo)};
         c_wdata = $urandom;
         if (!h_req && $urandom_range(0, 3) == 0) begin
            h_req   = 1'b1;
            h_we    = 1'($urandom_range(0, 1));
            h_addr  = ADDR_W'($urandom_range(0, 15));
            h_wdata = $urandom;
         end
         applyStimulus(c_req, c_we, c_size, c_uns, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata);
         @(negedge clk);
         checkOutput("rnd_host_gnt", 32'(host_gnt), 32'(owns));
         checkOutput("rnd_cpu_stall", 32'(cpu_stall), 32'(c_req && owns));
         checkOutput("rnd_host_rvalid", 32'(host_rvalid), 32'(exp_rv));
         checkOutput("rnd_misalign_err", 32'(misalign_err), 32'h0);
         if (exp_rv) checkOutput("rnd_host_rdata", host_rdata, exp_hrdata);
         if (c_req && !c_we && !owns)
            checkOutput("rnd_cpu_rdata", cpu_rdata, refLoad(ref_mem[w], c_size, c_uns, c_addr));

         nxt_rv = owns && !h_we;
         if (nxt_rv) exp_hrdata = ref_mem[h_addr[3:0]];
         if (owns) begin
            if (h_we) ref_mem[h_addr[3:0]] = h_wdata;
         end else if (c_req && c_we) begin
            ref_mem[w] = refStore(ref_mem[w], c_size, c_addr, c_wdata);
         end
         if (owns) begin
            nxt_owns = h_req && !c_req;
            denials  = 0;
         end else if (h_req && !c_req) begin
            nxt_owns = 1'b1;
            denials  = 0;
         end else if (h_req) begin
            denials++;
            nxt_owns = (denials == MAXW);
            if (nxt_owns) denials = 0;
         end else begin
            nxt_owns = 1'b0;
            denials  = 0;
         end
         if (owns && h_req) begin
            h_req = 1'b0;
            h_we  = 1'b0;
         end
         @(posedge clk); #1;
         owns   = nxt_owns;
         exp_rv = nxt_rv;
      end
      idle(3);
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("rnd_final_mem%0d", i), mem[i], ref_mem[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
